// File: rtl/bbox_pkg.sv
// Shared types and constants for the per-frame bounding-box tracker.
// Optional smoothing of committed boxes is enabled by defining BBOX_SMOOTH_EN.
package bbox_pkg;

    localparam int unsigned SCREEN_W = 1024;
    localparam int unsigned SCREEN_H = 768;

    typedef logic [11:0] coord_x_t;
    typedef logic [10:0] coord_y_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
        coord_x_t xmax;
        coord_y_t ymax;
    } box_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_FRAME = 2'd0;
    localparam state_t ST_ACCUM      = 2'd1;
    localparam state_t ST_COMMIT     = 2'd2;

    // Mean of two coordinates; the extra sum bit keeps the carry.
    function automatic coord_x_t avg_x(coord_x_t a, coord_x_t b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12:1];
    endfunction

    function automatic coord_y_t avg_y(coord_y_t a, coord_y_t b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[11:1];
    endfunction

endpackage

// File: rtl/bbox_tracker_minmax_accum.sv
// Single-axis min/max accumulator with init, seed and update controls.
// Init wins over update; a seeded init loads the pixel as both extremes.
module minmax_accum #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         seed,
    input  logic         upd,
    input  logic [W-1:0] val,
    output logic [W-1:0] min_val,
    output logic [W-1:0] max_val
);

    // Track running extremes, restarting on each frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val <= '1;
            max_val <= '0;
        end else if (init) begin
            min_val <= seed ? val : '1;
            max_val <= seed ? val : '0;
        end else if (upd) begin
            if (val < min_val) min_val <= val;
            if (val > max_val) max_val <= val;
        end
    end

endmodule

// File: rtl/bbox_tracker.sv
// Per-frame bounding-box extractor feeding the display stage.
// Define BBOX_SMOOTH_EN to average consecutive valid boxes on commit.
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int unsigned MAX_X      = SCREEN_W,
    parameter int unsigned MAX_Y      = SCREEN_H,
    parameter int unsigned MIN_PIXELS = 64,
    parameter int          CNT_W      = 20
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             nf_in,
    input  logic             pixel_valid_in,
    input  logic [11:0]      x_in,
    input  logic [10:0]      y_in,
    input  logic             mask_in,
    output logic [11:0]      box_x_out,
    output logic [10:0]      box_y_out,
    output logic [11:0]      box_xmax_out,
    output logic [10:0]      box_ymax_out,
    output logic             box_valid_out,
    output logic [CNT_W-1:0] pixel_count_out,
    output logic             update_out
);

    state_t           state;
    state_t           state_nx;
    logic             qual;
    logic             in_frame;
    logic             snap;
    coord_x_t         min_x;
    coord_x_t         max_x;
    coord_y_t         min_y;
    coord_y_t         max_y;
    logic [CNT_W-1:0] cnt;
    box_t             shadow_box;
    logic [CNT_W-1:0] shadow_cnt;
    logic             shadow_ok;
    box_t             box_q;
    box_t             new_box;

    assign qual = pixel_valid_in & mask_in
                & ({20'd0, x_in} < MAX_X)
                & ({21'd0, y_in} < MAX_Y);

    assign in_frame  = (state != ST_WAIT_FRAME);
    assign snap      = nf_in & in_frame;
    assign shadow_ok = (shadow_cnt >= CNT_W'(MIN_PIXELS));

    minmax_accum #(.W(12)) u_acc_x (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .init    (nf_in),
        .seed    (qual),
        .upd     (qual & in_frame),
        .val     (x_in),
        .min_val (min_x),
        .max_val (max_x)
    );

    minmax_accum #(.W(11)) u_acc_y (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .init    (nf_in),
        .seed    (qual),
        .upd     (qual & in_frame),
        .val     (y_in),
        .min_val (min_y),
        .max_val (max_y)
    );

    // Frame sequencing: wait for first frame, accumulate, commit.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_WAIT_FRAME: if (nf_in) state_nx = ST_ACCUM;
            ST_ACCUM:      if (nf_in) state_nx = ST_COMMIT;
            ST_COMMIT:     state_nx = nf_in ? ST_COMMIT : ST_ACCUM;
            default:       state_nx = ST_WAIT_FRAME;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_WAIT_FRAME;
        else           state <= state_nx;
    end

    // Saturating masked-pixel counter, seeded on the frame boundary.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (nf_in) begin
            cnt <= qual ? CNT_W'(1) : '0;
        end else if (qual && in_frame && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Snapshot the finished frame so accumulation can restart at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_box <= '0;
            shadow_cnt <= '0;
        end else if (snap) begin
            shadow_box <= '{x: min_x, y: min_y, xmax: max_x, ymax: max_y};
            shadow_cnt <= cnt;
        end
    end

    // Candidate box for commit, optionally blended with the last one.
    always_comb begin
        new_box = shadow_box;
`ifdef BBOX_SMOOTH_EN
        if (box_valid_out && shadow_ok) begin
            new_box.x    = avg_x(box_q.x,    shadow_box.x);
            new_box.y    = avg_y(box_q.y,    shadow_box.y);
            new_box.xmax = avg_x(box_q.xmax, shadow_box.xmax);
            new_box.ymax = avg_y(box_q.ymax, shadow_box.ymax);
        end
`endif
    end

    // Committed outputs, held stable between update pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            box_q           <= '0;
            box_valid_out   <= 1'b0;
            pixel_count_out <= '0;
            update_out      <= 1'b0;
        end else if (state == ST_COMMIT) begin
            if (shadow_ok) box_q <= new_box;
            box_valid_out   <= shadow_ok;
            pixel_count_out <= shadow_cnt;
            update_out      <= 1'b1;
        end else begin
            update_out      <= 1'b0;
        end
    end

    assign box_x_out    = box_q.x;
    assign box_y_out    = box_q.y;
    assign box_xmax_out = box_q.xmax;
    assign box_ymax_out = box_q.ymax;

endmodule

// File: tb/tb_bbox_tracker.sv
// Directed self-checking bench for bbox_tracker.
// Expected smoothed values apply when BBOX_SMOOTH_EN is defined.
module tb_bbox_tracker;

    logic        clk_in;
    logic        rst_n_in;
    logic        nf_in;
    logic        pixel_valid_in;
    logic [11:0] x_in;
    logic [10:0] y_in;
    logic        mask_in;
    logic [11:0] box_x_out;
    logic [10:0] box_y_out;
    logic [11:0] box_xmax_out;
    logic [10:0] box_ymax_out;
    logic        box_valid_out;
    logic [19:0] pixel_count_out;
    logic        update_out;

    int nvec  = 0;
    int nfail = 0;

    bbox_tracker dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .nf_in           (nf_in),
        .pixel_valid_in  (pixel_valid_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .mask_in         (mask_in),
        .box_x_out       (box_x_out),
        .box_y_out       (box_y_out),
        .box_xmax_out    (box_xmax_out),
        .box_ymax_out    (box_ymax_out),
        .box_valid_out   (box_valid_out),
        .pixel_count_out (pixel_count_out),
        .update_out      (update_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y,
                           input int xm, input int ym, input int v,
                           input int c, input int u);
        chk({tag, ".x"},     int'(box_x_out),       x);
        chk({tag, ".y"},     int'(box_y_out),       y);
        chk({tag, ".xmax"},  int'(box_xmax_out),    xm);
        chk({tag, ".ymax"},  int'(box_ymax_out),    ym);
        chk({tag, ".valid"}, int'(box_valid_out),   v);
        chk({tag, ".count"}, int'(pixel_count_out), c);
        chk({tag, ".upd"},   int'(update_out),      u);
    endtask

    // Inputs change on the falling edge; the DUT samples on the next rise.
    task automatic step(input logic v, input int x, input int y,
                        input logic m, input logic nf);
        pixel_valid_in = v;
        x_in           = x[11:0];
        y_in           = y[10:0];
        mask_in        = m;
        nf_in          = nf;
        @(negedge clk_in);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic add_box(input int x0, input int y0,
                           input int x1, input int y1);
        step(1'b1, x0, y0, 1'b1, 1'b0);
        step(1'b1, x1, y1, 1'b1, 1'b0);
        for (int i = 0; i < 62; i++)
            step(1'b1, x0 + 1 + i, y0 + 1 + i, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        nf_in          = 1'b0;
        pixel_valid_in = 1'b0;
        x_in           = '0;
        y_in           = '0;
        mask_in        = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n_in = 1'b1;

        // Pixels before the first frame start are dropped.
        step(1'b1, 2, 3, 1'b1, 1'b0);
        step(1'b1, 900, 700, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // Frame 1: 64 pixels spanning (100,50)-(300,200).
        add_box(100, 50, 300, 200);
        step(1'b1, 10, 10, 1'b0, 1'b0);
        step(1'b0, 5, 5, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        chk("f1.lat_upd", int'(update_out), 0);
        chk("f1.lat_x", int'(box_x_out), 0);
        idle();
        chk_all("f1", 100, 50, 300, 200, 1, 64, 1);
        idle();
        chk("f1.upd_drop", int'(update_out), 0);
        chk("f1.stable_x", int'(box_x_out), 100);

        // Frame 2: too few pixels, box held.
        for (int i = 0; i < 10; i++)
            step(1'b1, 500 + i, 400, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
        chk_all("f2", 100, 50, 300, 200, 0, 10, 1);

        // Frame 3: out-of-range pixels excluded; (5,5) on the nf cycle.
        step(1'b1, 1100, 10, 1'b1, 1'b0);
        step(1'b1, 30, 800, 1'b1, 1'b0);
        add_box(200, 150, 400, 300);
        step(1'b1, 5, 5, 1'b1, 1'b1);
        idle();
        chk_all("f3", 200, 150, 400, 300, 1, 64, 1);

        // Frame 4 seeded by (5,5); nf in COMMIT makes an empty frame.
        step(1'b1, 72, 72, 1'b1, 1'b0);
        for (int i = 0; i < 62; i++)
            step(1'b1, 6 + i, 6 + i, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
`ifdef BBOX_SMOOTH_EN
        chk_all("f4", 102, 77, 236, 186, 1, 64, 1);
        idle();
        chk_all("empty", 102, 77, 236, 186, 0, 0, 1);
`else
        chk_all("f4", 5, 5, 72, 72, 1, 64, 1);
        idle();
        chk_all("empty", 5, 5, 72, 72, 0, 0, 1);
`endif

        // Frames 6/7: valid after invalid is direct, then blended.
        add_box(100, 50, 300, 200);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
        chk_all("f6", 100, 50, 300, 200, 1, 64, 1);
        add_box(200, 150, 400, 300);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
`ifdef BBOX_SMOOTH_EN
        chk_all("f7", 150, 100, 350, 250, 1, 64, 1);
`else
        chk_all("f7", 200, 150, 400, 300, 1, 64, 1);
`endif

        // Reset mid-frame clears outputs without a clock edge.
        step(1'b1, 20, 20, 1'b1, 1'b0);
        step(1'b1, 30, 30, 1'b1, 1'b0);
        #2 rst_n_in = 1'b0;
        #1 chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // After reset, only post-nf pixels reach the first commit.
        step(1'b1, 1, 1, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        add_box(100, 50, 300, 200);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle();
        chk_all("postrst", 100, 50, 300, 200, 1, 64, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
